// File: rtl/wb_sram_burst_slave.sv
// Wishbone B4 registered-feedback SRAM slave: classic cycles plus linear and
// wrap-4/8/16 incrementing bursts, byte-lane writes, ERR outside the window.
module wb_sram_burst_slave #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int MEM_ADDR_BITS = 10,
  parameter logic [WB_ADDR_WIDTH-1:0] ADDR_BASE = '0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [WB_ADDR_WIDTH-1:0]   ADR,
  input  logic [2:0]                 CTI,
  input  logic [1:0]                 BTE,
  input  logic [WB_DATA_WIDTH-1:0]   DAT_W,
  output logic [WB_DATA_WIDTH-1:0]   DAT_R,
  input  logic                       CYC,
  input  logic                       STB,
  input  logic [WB_DATA_WIDTH/8-1:0] SEL,
  input  logic                       WE,
  output logic                       ACK,
  output logic                       ERR
);

  localparam int LANES = WB_DATA_WIDTH / 8;
  localparam int LSB   = $clog2(LANES);
  localparam int DEPTH = 1 << MEM_ADDR_BITS;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                   state;
  logic                     ack_q;
  logic                     err_q;
  logic [MEM_ADDR_BITS-1:0] waddr;

  logic [WB_ADDR_WIDTH-1:0] offset;
  logic [WB_ADDR_WIDTH-1:0] word_off;
  logic                     in_range;
  logic [MEM_ADDR_BITS-1:0] adr_idx;
  logic [MEM_ADDR_BITS-1:0] mask;
  logic [MEM_ADDR_BITS-1:0] next_addr;
  logic [MEM_ADDR_BITS-1:0] rd_addr;
  logic                     bus_req;
  logic                     start;
  logic                     burst_go;
  logic                     lin_end;
  logic                     rd_en;
  logic                     wr_en;

  assign offset   = ADR - ADDR_BASE;
  assign word_off = offset >> LSB;
  assign in_range = (word_off >> MEM_ADDR_BITS) == '0;
  assign adr_idx  = word_off[MEM_ADDR_BITS-1:0];

  always_comb begin
    mask = '0;
    case (BTE)
      2'b01:   mask = MEM_ADDR_BITS'(3);
      2'b10:   mask = MEM_ADDR_BITS'(7);
      2'b11:   mask = MEM_ADDR_BITS'(15);
      default: mask = '0;
    endcase
  end

  assign next_addr = (BTE == 2'b00) ? waddr + 1'b1
                                    : (waddr & ~mask) | ((waddr + 1'b1) & mask);

  assign bus_req  = CYC & STB;
  assign ACK      = ack_q & bus_req;
  assign ERR      = err_q & bus_req;
  assign start    = (state == IDLE) & bus_req & ~ack_q & ~err_q;
  assign burst_go = (state == ACTIVE) & ACK & (CTI == 3'b010);
  // A linear burst stepping past the last word turns its next beat into ERR.
  assign lin_end  = (BTE == 2'b00) & (&waddr);
  assign rd_en    = (start & in_range) | (burst_go & ~lin_end);
  assign rd_addr  = start ? adr_idx : next_addr;
  assign wr_en    = rstn & ACK & WE;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      waddr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            waddr <= adr_idx;
            ack_q <= in_range;
            err_q <= ~in_range;
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (burst_go) begin
            if (lin_end) begin
              ack_q <= 1'b0;
              err_q <= 1'b1;
            end else begin
              waddr <= next_addr;
            end
          end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One byte-wide array per lane keeps lane enables as independent RAM writes.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_byte;

    always_ff @(posedge clk) begin
      if (wr_en && SEL[gi]) begin
        mem[waddr] <= DAT_W[gi*8 +: 8];
      end
    end

    always_ff @(posedge clk) begin
      if (!rstn) begin
        rd_byte <= '0;
      end else if (rd_en) begin
        rd_byte <= mem[rd_addr];
      end
    end

    assign DAT_R[gi*8 +: 8] = rd_byte;
  end

endmodule

// File: tb/tb_wb_sram_burst_slave.sv
// Randomised and directed bench for wb_sram_burst_slave against a beat-level
// reference model of the slave's response and its memory contents.
module tb_wb_sram_burst_slave;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] ADR;
  logic [2:0]  CTI;
  logic [1:0]  BTE;
  logic [31:0] DAT_W;
  logic [31:0] DAT_R;
  logic        CYC;
  logic        STB;
  logic [3:0]  SEL;
  logic        WE;
  logic        ACK;
  logic        ERR;

  always #5 clk = ~clk;

  wb_sram_burst_slave dut (
    .clk(clk), .rstn(rstn), .ADR(ADR), .CTI(CTI), .BTE(BTE),
    .DAT_W(DAT_W), .DAT_R(DAT_R), .CYC(CYC), .STB(STB), .SEL(SEL),
    .WE(WE), .ACK(ACK), .ERR(ERR)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int next_word(input int w, input logic [1:0] bte);
    int len;
    len = (bte == 2'b00) ? 0 : (2 << bte);
    if (len == 0) return w + 1;
    return (w / len) * len + (w + 1) % len;
  endfunction

  function automatic logic [31:0] fill_val(input int i);
    return 32'hC0DE0000 | 32'(i);
  endfunction

  // Reference model: m_kind 0 = no response pending, 1 = ACK beat, 2 = ERR beat.
  logic [31:0] m_mem [DEPTH];
  int          m_kind = 0;
  int          m_addr = 0;
  bit          chk_en = 1'b0;
  bit          exp_ack;
  bit          exp_err;

  always @(posedge clk) begin
    if (!rstn) begin
      m_kind <= 0;
    end else begin
      if (m_kind == 1 && CYC && STB && WE)
        for (int i = 0; i < 4; i++)
          if (SEL[i]) m_mem[m_addr][8*i +: 8] <= DAT_W[8*i +: 8];
      if (m_kind == 0) begin
        if (CYC && STB) begin
          m_addr <= int'(ADR[11:2]);
          m_kind <= (ADR < 32'd4096) ? 1 : 2;
        end
      end else if (!(CYC && STB)) begin
        m_kind <= 0;
      end else if (m_kind == 1 && CTI == 3'b010) begin
        if (BTE == 2'b00 && m_addr == DEPTH - 1) m_kind <= 2;
        else m_addr <= next_word(m_addr, BTE);
      end else begin
        m_kind <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      exp_ack = (m_kind == 1) && CYC && STB;
      exp_err = (m_kind == 2) && CYC && STB;
      chk("ack", {31'b0, ACK}, {31'b0, exp_ack});
      chk("err", {31'b0, ERR}, {31'b0, exp_err});
      if (exp_ack && !WE) chk("dat_r", DAT_R, m_mem[m_addr]);
    end
  end

  logic [31:0] rd_q[$];
  int          kind_q[$];
  int          lat_q[$];
  logic [31:0] wq[$];

  task automatic wait_resp(output int got);
    got = 0;
    for (int i = 0; i < 8 && got == 0; i++) begin
      @(negedge clk);
      if (ACK) got = 1;
      else if (ERR) got = 2;
    end
  endtask

  task automatic burst(input logic [31:0] adr, input int n, input logic [1:0] bte,
                       input logic we, input logic [3:0] sel, input int gap_after,
                       input bit hold_inc);
    int w;
    int lat;
    int got;
    rd_q.delete(); kind_q.delete(); lat_q.delete();
    w = int'(adr >> 2);
    CYC = 1'b1; STB = 1'b1; WE = we; BTE = bte; ADR = adr;
    for (int b = 0; b < n; b++) begin
      if (b > 0) ADR = 32'(w) << 2;
      CTI = hold_inc ? 3'b010 : (n == 1) ? 3'b000 : (b == n - 1) ? 3'b111 : 3'b010;
      SEL = sel;
      DAT_W = (wq.size() > 0) ? wq.pop_front() : $urandom;
      got = 0;
      lat = 0;
      while (got == 0 && lat < 8) begin
        @(negedge clk);
        lat++;
        if (ACK) begin
          got = 1;
          if (!WE) rd_q.push_back(DAT_R);
        end else if (ERR) begin
          got = 2;
        end
      end
      if (got == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL beat_timeout: no ACK/ERR within 8 cycles at word %0d, expected a response", w);
      end
      kind_q.push_back(got);
      lat_q.push_back(lat - 1);
      @(posedge clk); #1;
      if (got != 1) break;
      w = next_word(w, bte);
      if (b == gap_after && b < n - 1) begin
        STB = 1'b0;
        @(negedge clk);
        chk("gap_ack", {31'b0, ACK}, 32'd0);
        @(posedge clk); #1;
        STB = 1'b1;
      end
    end
    CYC = 1'b0; STB = 1'b0; WE = 1'b0; CTI = 3'b000;
    $display("txn adr=%h n=%0d bte=%0d we=%0b beats=%0d", adr, n, bte, we, kind_q.size());
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic [31:0] adr;
    int n;
    int gap;
    int r;
    logic [1:0] bte;
    logic we;
    logic [3:0] sel;

    rstn = 1'b0; CYC = 1'b0; STB = 1'b0; WE = 1'b0; ADR = '0; CTI = '0;
    BTE = '0; DAT_W = '0; SEL = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_ack", {31'b0, ACK}, 32'd0);
    chk("reset_err", {31'b0, ERR}, 32'd0);
    chk("reset_dat_r", DAT_R, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < DEPTH; i++) wq.push_back(fill_val(i));
    burst(32'h0, DEPTH, 2'b00, 1'b1, 4'hF, -1, 1'b0);
    chk("fill_beats", 32'(kind_q.size()), 32'd1024);

    wq.push_back(32'hDEADBEEF);
    burst(32'h10, 1, 2'b00, 1'b1, 4'hF, -1, 1'b0);
    chk("classic_wr_lat", 32'(lat_q[0]), 32'd1);
    burst(32'h10, 1, 2'b00, 1'b0, 4'hF, -1, 1'b0);
    chk("classic_rd_lat", 32'(lat_q[0]), 32'd1);
    chk("classic_rd_data", rd_q[0], 32'hDEADBEEF);

    wq.push_back(32'h11223344);
    burst(32'd20, 1, 2'b00, 1'b1, 4'hF, -1, 1'b0);
    wq.push_back(32'hAABBCCDD);
    burst(32'd20, 1, 2'b00, 1'b1, 4'b0101, -1, 1'b0);
    burst(32'd20, 1, 2'b00, 1'b0, 4'hF, -1, 1'b0);
    chk("byte_lanes", rd_q[0], 32'h11BB33DD);

    wq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    burst(32'h0, 4, 2'b00, 1'b1, 4'hF, -1, 1'b0);
    burst(32'h8, 4, 2'b01, 1'b0, 4'hF, -1, 1'b0);
    chk("wrap4_beats", 32'(rd_q.size()), 32'd4);
    chk("wrap4_d0", rd_q[0], 32'hA2);
    chk("wrap4_d1", rd_q[1], 32'hA3);
    chk("wrap4_d2", rd_q[2], 32'hA0);
    chk("wrap4_d3", rd_q[3], 32'hA1);
    chk("wrap4_zero_wait", 32'(lat_q[3]), 32'd0);

    burst(32'd1022 * 4, 3, 2'b00, 1'b0, 4'hF, -1, 1'b1);
    chk("offend_k0", 32'(kind_q[0]), 32'd1);
    chk("offend_k1", 32'(kind_q[1]), 32'd1);
    chk("offend_k2_err", 32'(kind_q[2]), 32'd2);
    chk("offend_d0", rd_q[0], 32'hC0DE03FE);
    chk("offend_d1", rd_q[1], 32'hC0DE03FF);

    burst(32'd400, 4, 2'b00, 1'b0, 4'hF, 1, 1'b0);
    chk("gap_restart_lat", 32'(lat_q[2]), 32'd1);
    chk("gap_restart_data", rd_q[2], 32'hC0DE0066);
    chk("gap_last_data", rd_q[3], 32'hC0DE0067);

    wq = '{32'h5A5A0040, 32'h5A5A0041, 32'h5A5A0042, 32'h5A5A0043};
    burst(32'd160, 4, 2'b00, 1'b1, 4'hF, -1, 1'b0);
    CYC = 1'b1; STB = 1'b1; WE = 1'b1; CTI = 3'b010; BTE = 2'b00; SEL = 4'hF;
    ADR = 32'd160; DAT_W = 32'h01010101;
    wait_resp(g);
    chk("rst_beat0", 32'(g), 32'd1);
    @(posedge clk); #1;
    ADR = 32'd164; DAT_W = 32'h02020202;
    wait_resp(g);
    chk("rst_beat1", 32'(g), 32'd1);
    @(posedge clk); #1;
    ADR = 32'd168; DAT_W = 32'hFFFFFFFF;
    wait_resp(g);
    chk("rst_beat2", 32'(g), 32'd1);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_ack_after", {31'b0, ACK}, 32'd0);
    @(posedge clk); #1;
    CYC = 1'b0; STB = 1'b0; WE = 1'b0; CTI = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    burst(32'd168, 1, 2'b00, 1'b0, 4'hF, -1, 1'b0);
    chk("rst_word_kept", rd_q[0], 32'h5A5A0042);
    burst(32'd164, 1, 2'b00, 1'b0, 4'hF, -1, 1'b0);
    chk("rst_prev_written", rd_q[0], 32'h02020202);

    burst(32'd4096, 1, 2'b00, 1'b1, 4'hF, -1, 1'b0);
    chk("oor_err", 32'(kind_q[0]), 32'd2);
    chk("oor_lat", 32'(lat_q[0]), 32'd1);
    burst(32'h0, 1, 2'b00, 1'b0, 4'hF, -1, 1'b0);
    chk("oor_word0_kept", rd_q[0], 32'hA0);

    for (int t = 0; t < 80; t++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) adr = 32'd4096 + ($urandom_range(0, 255) << 2);
      else if (r == 1) adr = 32'($urandom_range(1020, 1023)) << 2;
      else adr = 32'($urandom_range(0, 1023)) << 2;
      adr = adr | 32'($urandom_range(0, 3));
      n   = int'($urandom_range(1, 16));
      bte = 2'($urandom_range(0, 3));
      we  = 1'($urandom_range(0, 1));
      sel = 4'($urandom_range(0, 15));
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      if (r == 1) bte = 2'b00;
      burst(adr, n, bte, we, sel, gap, r == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
